// File: rtl/turn_sequencer.sv
// turn_sequencer: game-tick controller upstream of the storage block.
// Latches both players' keys every cycle. Once per game tick it walks storage
// through the four object slots (tank 1, projectile 1, tank 2, projectile 2).
// Each slot takes three cycles (SEL, CALC, LOAD), and a DONE cycle follows the
// last slot. The block also owns the projectile state: active flag, heading
// and remaining lifetime.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      synchronous, active-low reset
//   p1_keys    player 1 {fire,right,left,down,up}, active-high level
//   p2_keys    player 2, same encoding
//   mode       storage mode select (4'b1001 = idle, selects nothing)
//   load_out   one-cycle strobe in the LOAD cycle of each slot
//   address    RAM address, constant 8'h00
//   data       movement command for the current slot (8'hFF = no move)
//   busy       high while a tick sequence is in progress
//   tick_done  one-cycle pulse after the last slot is loaded
module turn_sequencer #(
    parameter int unsigned TICK_CYCLES = 25000000,
    parameter int unsigned PROJ_LIFE   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] p1_keys,
    input  logic [4:0] p2_keys,
    output logic [3:0] mode,
    output logic       load_out,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       busy,
    output logic       tick_done
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [3:0]       LIFE_INIT = 4'(PROJ_LIFE);
    localparam logic [3:0]       MODE_IDLE = 4'b1001;
    localparam logic [7:0]       DIR_UP    = 8'h00;
    localparam logic [7:0]       DIR_DOWN  = 8'h01;
    localparam logic [7:0]       DIR_LEFT  = 8'h03;
    localparam logic [7:0]       DIR_RIGHT = 8'h07;
    localparam logic [7:0]       NO_MOVE   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CALC,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [1:0]       slot, slot_n;
    logic [CNT_W-1:0] cnt;

    logic [3:0] mode_n;
    logic [7:0] data_n;
    logic [7:0] slot_cmd;
    logic       load_n, busy_n, done_n;

    // Per-player state, index 0 = player 1, index 1 = player 2
    logic [4:0] keys      [2];
    logic [7:0] pend_move [2];
    logic [7:0] facing    [2];
    logic [7:0] proj_dir  [2];
    logic [3:0] proj_life [2];
    logic [1:0] pend_fire;
    logic [1:0] proj_act;
    logic [1:0] load_tank;
    logic [1:0] load_proj;

    assign keys[0] = p1_keys;
    assign keys[1] = p2_keys;
    assign address = 8'h00;

    // Direction priority when several keys are held: up > down > left > right
    function automatic logic [7:0] key_code(input logic [4:0] k);
        if (k[0])      return DIR_UP;
        else if (k[1]) return DIR_DOWN;
        else if (k[2]) return DIR_LEFT;
        else if (k[3]) return DIR_RIGHT;
        else           return NO_MOVE;
    endfunction

    // Which player's tank or projectile is being loaded this cycle
    always_comb begin
        load_tank = 2'b00;
        load_proj = 2'b00;
        if (state == S_LOAD) begin
            if (slot[0]) load_proj[slot[1]] = 1'b1;
            else         load_tank[slot[1]] = 1'b1;
        end
    end

    // Next-state and next-output logic; outputs are registered with the state
    always_comb begin
        state_n  = state;
        slot_n   = slot;
        mode_n   = MODE_IDLE;
        data_n   = NO_MOVE;
        load_n   = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        slot_cmd = NO_MOVE;

        unique case (state)
            S_IDLE: begin
                // A tick landing while busy is simply dropped
                if (cnt == CNT_LAST) begin
                    state_n = S_SEL;
                    slot_n  = 2'd0;
                end
            end
            S_SEL:  state_n = S_CALC;
            S_CALC: state_n = S_LOAD;
            S_LOAD: begin
                if (slot == 2'd3) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_SEL;
                    slot_n  = slot + 2'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Command captured on SEL entry and held through CALC and LOAD
        if (slot_n[0]) slot_cmd = proj_act[slot_n[1]] ? proj_dir[slot_n[1]] : NO_MOVE;
        else           slot_cmd = pend_move[slot_n[1]];

        case (state_n)
            S_SEL: begin
                mode_n = {1'b0, slot_n, 1'b1};
                data_n = slot_cmd;
                busy_n = 1'b1;
            end
            S_CALC: begin
                mode_n = {1'b0, slot_n, 1'b1};
                data_n = data;
                busy_n = 1'b1;
            end
            S_LOAD: begin
                mode_n = {1'b0, slot_n, 1'b1};
                data_n = data;
                load_n = 1'b1;
                busy_n = 1'b1;
            end
            S_DONE: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            slot      <= 2'd0;
            mode      <= MODE_IDLE;
            data      <= NO_MOVE;
            load_out  <= 1'b0;
            busy      <= 1'b0;
            tick_done <= 1'b0;
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            mode      <= mode_n;
            data      <= data_n;
            load_out  <= load_n;
            busy      <= busy_n;
            tick_done <= done_n;
        end
    end

    // Tick counter and per-player key / projectile state
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            pend_fire <= 2'b00;
            proj_act  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                pend_move[1'(i)] <= NO_MOVE;
                proj_dir[1'(i)]  <= DIR_UP;
                proj_life[1'(i)] <= 4'd0;
            end
            facing[0] <= DIR_DOWN;
            facing[1] <= DIR_UP;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            for (int i = 0; i < 2; i++) begin
                // Consumed at LOAD; a press in that same cycle wins below
                if (load_tank[1'(i)]) begin
                    pend_move[1'(i)] <= NO_MOVE;
                    if (data != NO_MOVE) facing[1'(i)] <= data;
                end
                if (key_code(keys[1'(i)]) != NO_MOVE)
                    pend_move[1'(i)] <= key_code(keys[1'(i)]);

                // Fire while active is discarded; spawn heads where the tank faces
                if (load_proj[1'(i)]) begin
                    pend_fire[1'(i)] <= 1'b0;
                    if (proj_act[1'(i)]) begin
                        proj_life[1'(i)] <= proj_life[1'(i)] - 4'd1;
                        if (proj_life[1'(i)] == 4'd1) proj_act[1'(i)] <= 1'b0;
                    end else if (pend_fire[1'(i)]) begin
                        proj_act[1'(i)]  <= 1'b1;
                        proj_dir[1'(i)]  <= facing[1'(i)];
                        proj_life[1'(i)] <= LIFE_INIT;
                    end
                end
                if (keys[1'(i)][4]) pend_fire[1'(i)] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with TICK_CYCLES=8. Expected slot commands
// are queued when keys are driven and popped at each slot's SEL cycle.
module tb_turn_sequencer;

    localparam int unsigned TICKS = 8;
    localparam int unsigned LIFE  = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] p1_keys, p2_keys;
    logic [3:0] mode;
    logic       load_out, busy, tick_done;
    logic [7:0] address, data;

    int vecs = 0;
    int errs = 0;
    logic [7:0] exp_q[$];

    turn_sequencer #(.TICK_CYCLES(TICKS), .PROJ_LIFE(LIFE)) dut (
        .clk(clk), .reset(reset), .p1_keys(p1_keys), .p2_keys(p2_keys),
        .mode(mode), .load_out(load_out), .address(address), .data(data),
        .busy(busy), .tick_done(tick_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Idle / reset output state: mode, load, busy, done, address, data
    task automatic check_idle(input string tag);
        chk(tag, 32'({mode, load_out, busy, tick_done, address, data}),
            32'({4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF}));
    endtask

    task automatic push4(input logic [7:0] t1, input logic [7:0] q1,
                         input logic [7:0] t2, input logic [7:0] q2);
        exp_q.push_back(t1);
        exp_q.push_back(q1);
        exp_q.push_back(t2);
        exp_q.push_back(q2);
    endtask

    // Wait for one tick sequence and check all 13 cycles of it.
    // load_keys is driven on p1 during the T1 LOAD cycle; abort_k asserts reset.
    task automatic run_tick(input int exp_gap, input logic [4:0] load_keys, input int abort_k);
        int gap;
        bit started;
        logic [7:0] cur;
        gap = 0;
        started = 1'b0;
        cur = 8'hFF;
        for (int n = 0; n < 40 && !started; n++) begin
            @(negedge clk);
            if (busy === 1'b1) started = 1'b1;
            else begin
                check_idle($sformatf("idle gap%0d", gap));
                gap++;
            end
        end
        chk("tick_start", 32'(started), 32'd1);
        if (!started) return;
        if (exp_gap >= 0) chk("idle_gap", 32'(gap), 32'(exp_gap));
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 12) begin
                int s;
                int ph;
                logic [1:0] s2;
                s  = (k - 1) / 3;
                ph = (k - 1) % 3;
                s2 = 2'(s);
                if (ph == 0) begin
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    else begin
                        errs++;
                        $display("FAIL scoreboard_empty observed=empty expected=entry");
                    end
                end
                chk($sformatf("seq k%0d", k),
                    32'({mode, load_out, busy, tick_done, address}),
                    32'({1'b0, s2, 1'b1, (ph == 2), 1'b1, 1'b0, 8'h00}));
                chk($sformatf("data slot%0d k%0d", s, k), 32'(data), 32'(cur));
            end else begin
                chk("done k13", 32'({mode, load_out, busy, tick_done, address, data}),
                    32'({4'b1001, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF}));
            end
            if (k == 3 && load_keys != 5'd0) p1_keys = load_keys;
            if (k == 4 && load_keys != 5'd0) p1_keys = 5'd0;
            if (k == abort_k) begin
                reset = 1'b0;
                exp_q.delete();
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        p1_keys = 5'd0;
        p2_keys = 5'd0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset = 1'b1;

        // No keys: idle until the counter wraps, then all-FF sequences; alternate ticks dropped
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(7, 5'd0, 0);
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(3, 5'd0, 0);

        // Later press overwrites; up beats down
        p1_keys = 5'b00100; @(negedge clk);
        p1_keys = 5'b00011; @(negedge clk);
        p1_keys = 5'd0;
        push4(8'h00, 8'hFF, 8'hFF, 8'hFF);
        run_tick(-1, 5'd0, 0);
        // Down pressed during T1 LOAD survives into the next tick
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(3, 5'b00010, 0);
        p2_keys = 5'b01110; @(negedge clk);
        p2_keys = 5'd0;
        push4(8'h01, 8'hFF, 8'h01, 8'hFF);
        run_tick(-1, 5'd0, 0);

        // Reset during T2 CALC clears pending left and fire
        p2_keys = 5'b10100; @(negedge clk);
        p2_keys = 5'd0;
        push4(8'hFF, 8'hFF, 8'h03, 8'hFF);
        run_tick(-1, 5'd0, 8);
        repeat (3) begin
            @(negedge clk);
            check_idle("mid_reset");
        end
        reset = 1'b1;
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(7, 5'd0, 0);
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(3, 5'd0, 0);

        // p2 fire from reset: spawn tick, 15 moves up, then expiry; fire while active ignored
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        p2_keys = 5'b10000; @(negedge clk);
        p2_keys = 5'd0;
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(-1, 5'd0, 0);
        for (int t = 0; t < 15; t++) begin
            if (t == 4) begin
                p2_keys = 5'b10000; @(negedge clk);
                p2_keys = 5'd0;
            end
            push4(8'hFF, 8'hFF, 8'hFF, 8'h00);
            run_tick(-1, 5'd0, 0);
        end
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(-1, 5'd0, 0);
        push4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        run_tick(3, 5'd0, 0);

        // p1 right + fire together: projectile follows the new facing
        p1_keys = 5'b11000; @(negedge clk);
        p1_keys = 5'd0;
        push4(8'h07, 8'hFF, 8'hFF, 8'hFF);
        run_tick(-1, 5'd0, 0);
        push4(8'hFF, 8'h07, 8'hFF, 8'hFF);
        run_tick(3, 5'd0, 0);
        push4(8'hFF, 8'h07, 8'hFF, 8'hFF);
        run_tick(3, 5'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Game-tick controller sitting directly upstream of the storage block. It latches both players' button inputs, and once per game tick steps storage through the four object slots: tank 1, tank 1 projectile, tank 2, tank 2 projectile. For each slot it drives mode, data (movement command) and the load_out strobe. It also owns projectile state: fire/active flag, heading and remaining lifetime.

Parameters:
TICK_CYCLES, 25000000, clock cycles per game tick (0.5 s at 50 MHz); benches use 8.
PROJ_LIFE, 15, number of moves a fired projectile makes before it expires; range 1..15.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset.
p1_keys  in  5  player 1 {fire,right,left,down,up}, active-high level.
p2_keys  in  5  player 2, same encoding.
mode  out  4  storage mode select.
load_out  out  1  one-cycle strobe; storage latches its result register on it.
address  out  8  RAM address; constant 8'h00.
data  out  8  movement command to storage.
busy  out  1  high while a tick sequence is in progress.
tick_done  out  1  one-cycle pulse after the last slot is loaded.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low: on the posedge where reset==0, all state is loaded with reset values.
- Reset values:
  - Outputs: mode=4'b1001 (idle code, selects no register and no RAM write), load_out=0, address=8'h00, data=8'hFF, busy=0, tick_done=0.
  - Internal: tick counter=0; pending moves and fire flags cleared; projectiles inactive; facing t1=8'h01 (down), t2=8'h00 (up).
- Direction codes: up 8'h00, down 8'h01, left 8'h03, right 8'h07. No-move code is 8'hFF; storage passes position through unchanged.
- Key latching, every cycle per player:
  - Any direction key high: pending_move <= that code.
  - Several direction keys high in one cycle: priority up>down>left>right.
  - A later press overwrites an earlier one within the same tick.
  - fire high: pending_fire <= 1.
- Tick counter: counts 0..TICK_CYCLES-1, then wraps to 0.
  - On the cycle it equals TICK_CYCLES-1 with FSM in IDLE, the FSM enters SEL for slot T1.
  - If the FSM is not IDLE at that point, the tick is dropped; the counter keeps running.
- FSM states: IDLE -> per slot {SEL -> CALC -> LOAD} -> next slot -> DONE -> IDLE.
  - Slot order and mode codes: T1 4'b0001, P1 4'b0011, T2 4'b0101, P2 4'b0111.
  - Sequence length: 12 slot cycles plus 1 DONE cycle.
- SEL/CALC/LOAD: mode = slot code and data = slot command, held constant across all three cycles. load_out=1 only in LOAD.
- DONE: mode=4'b1001, data=8'hFF, tick_done=1.
- IDLE: mode=4'b1001, data=8'hFF.
- busy=1 in every state except IDLE.
- Tank slot command:
  - If a move is pending: data=pending code, facing <= code, pending_move cleared at LOAD.
  - Otherwise data=8'hFF.
  - Key presses arriving during the LOAD cycle of that slot are kept for the next tick.
- Projectile slot command:
  - Active: data = proj_dir and life decrements at LOAD. Reaching 0 sets the projectile inactive.
  - Inactive with pending_fire: the projectile becomes active, proj_dir <= current facing (after this tick's tank move), life <= PROJ_LIFE. data=8'hFF for this tick (spawn at the tank).
  - Fire while active: pending_fire is cleared and ignored.
- Clearing: all pending flags consumed by a slot clear at that slot's LOAD cycle; new presses in that same cycle win.
- address is constant 8'h00. mode never equals 4'b0000, so this block never writes RAM.
- Reset mid-sequence returns to IDLE next cycle with all reset values. No partial load_out is issued.

Test Plan:
1. Reset held 3 cycles, then released with no keys, TICK_CYCLES=8 -> mode=1001, data=FF, busy=0 until cycle 7. Then a 13-cycle sequence: modes 0001x3, 0011x3, 0101x3, 0111x3, all data=FF; load_out pulses on cycles 3,6,9,12 of the sequence; tick_done on cycle 13.
2. p1 left held 1 cycle, then p1 up and down together 1 cycle, before the tick -> T1 slot data=8'h00; next tick T1 data=8'hFF.
3. p2 fire pulse at reset state -> P2 slot data=FF on the first tick. Following ticks: P2 data=8'h00 for 15 ticks, then FF. A fire during the active period produces no respawn.
4. p1 right and fire in the same tick -> T1 data=07; P1 data=FF this tick, then 07 on the following ticks.
5. reset driven low during the CALC state of slot T2 -> next cycle mode=1001, load_out=0, busy=0, no tick_done; pending key state cleared.
6. TICK_CYCLES=8 with the sequence forced to overlap (hold FSM check) -> the overlapping tick is dropped; the counter wraps 7->0 without restarting the sequence.
